// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 responder.
// Holds the FSM state type, word width, fill word and counter sizing.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int SPI_WIDTH = 8;

   localparam logic [7:0] SPI_FILL = 8'h00;

   function automatic int cnt_bits(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous input bit.
// The reset value sets the idle level seen before real data arrives.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // shift the pin value through the flop chain
   always_ff @(posedge clk) begin
      if (rst) sr <= {STAGES{RST_VAL}};
      else     sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled SCLK/CS_n/MOSI, MSB-first bytes.
// Define SPI_UNDERRUN_EN to add the sticky o_TX_Underrun flag.
module spi_responder
   import spi_pkg::*;
#(
   parameter int               WIDTH       = SPI_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] FILL_BYTE   = WIDTH'(SPI_FILL)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_SPI_Clk,
   input  logic             i_SPI_CS_n,
   input  logic             i_SPI_MOSI,
   output logic             o_SPI_MISO,
   output logic             o_RX_DV,
   output logic [WIDTH-1:0] o_RX_Byte,
   input  logic             i_TX_DV,
   input  logic [WIDTH-1:0] i_TX_Byte,
   output logic             o_TX_Ready,
`ifdef SPI_UNDERRUN_EN
   output logic             o_TX_Underrun,
`endif
   output logic             o_Busy
);

   localparam int CW = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic sclk_s, csn_s, mosi_s;
   logic sclk_d, csn_d;
   logic rise, fall, cs_fall;

   logic [SYNC_STAGES-1:0] primed;
   logic                   armed;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-2:0]  rx_shift;
   logic [WIDTH-1:0]  tx_shift;
   logic [WIDTH-1:0]  hold;
   logic              hold_full;
   logic              miso;
   logic              rx_dv;
   logic [WIDTH-1:0]  rx_byte;

   logic             accept, start, load;
   logic [WIDTH-1:0] word_in;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk (i_clk),
      .rst (i_rst),
      .d   (i_SPI_Clk),
      .q   (sclk_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
      .clk (i_clk),
      .rst (i_rst),
      .d   (i_SPI_CS_n),
      .q   (csn_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk (i_clk),
      .rst (i_rst),
      .d   (i_SPI_MOSI),
      .q   (mosi_s)
   );

   // delayed copies for edge detection
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_d <= 1'b0;
         csn_d  <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         csn_d  <= csn_s;
      end
   end

   assign rise    = sclk_s & ~sclk_d;
   assign fall    = ~sclk_s & sclk_d;
   assign cs_fall = ~csn_s & csn_d;

   // arm frame start only after a genuine high CS_n once the syncs flush
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         primed <= '0;
         armed  <= 1'b0;
      end else begin
         primed <= {primed[SYNC_STAGES-2:0], 1'b1};
         if (primed[SYNC_STAGES-1] && csn_s) armed <= 1'b1;
      end
   end

   assign accept  = i_TX_DV & ~hold_full;
   assign start   = cs_fall & armed;
   assign word_in = hold_full ? hold : FILL_BYTE;
   assign load    = ((state == IDLE) && start) ||
                    ((state == ACTIVE) && !csn_s && rise && (cnt == LAST));

   // TX holding register: accept when empty, drained by word loads
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept)    hold <= i_TX_Byte;
         if (accept)    hold_full <= 1'b1;
         else if (load) hold_full <= 1'b0;
      end
   end

`ifdef SPI_UNDERRUN_EN
   logic underrun;

   // sticky underrun: set on a fill load, cleared by the next accept
   always_ff @(posedge i_clk) begin
      if (i_rst)                   underrun <= 1'b0;
      else if (load && !hold_full) underrun <= 1'b1;
      else if (accept)             underrun <= 1'b0;
   end

   assign o_TX_Underrun = underrun;
`endif

   // frame FSM with bit counter, shift registers and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         miso     <= 1'b0;
         rx_dv    <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rx_dv <= 1'b0;
         unique case (state)
            IDLE: begin
               miso <= 1'b0;
               cnt  <= '0;
               if (start) begin
                  state    <= ACTIVE;
                  tx_shift <= word_in;
                  miso     <= word_in[WIDTH-1];
               end
            end
            ACTIVE: begin
               if (csn_s) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  miso     <= 1'b0;
                  rx_shift <= '0;
               end else if (rise) begin
                  rx_shift <= {rx_shift[WIDTH-3:0], mosi_s};
                  if (cnt == LAST) begin
                     cnt      <= '0;
                     rx_byte  <= {rx_shift, mosi_s};
                     rx_dv    <= 1'b1;
                     tx_shift <= word_in;
                     miso     <= word_in[WIDTH-1];
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (fall && (cnt != '0)) begin
                  tx_shift <= tx_shift << 1;
                  miso     <= tx_shift[WIDTH-2];
               end
            end
         endcase
      end
   end

   assign o_SPI_MISO = miso;
   assign o_RX_DV    = rx_dv;
   assign o_RX_Byte  = rx_byte;
   assign o_TX_Ready = ~hold_full;
   assign o_Busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: SPI master model plus word-level reference.
// Define SPI_UNDERRUN_EN to also check o_TX_Underrun.
module tb_spi_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, csn, mosi, miso;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       tx_ready;
   logic       busy;
`ifdef SPI_UNDERRUN_EN
   logic       under;
   bit         m_under = 0;
`endif

   always #5 clk = ~clk;

   spi_responder dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_SPI_Clk     (sclk),
      .i_SPI_CS_n    (csn),
      .i_SPI_MOSI    (mosi),
      .o_SPI_MISO    (miso),
      .o_RX_DV       (rx_dv),
      .o_RX_Byte     (rx_byte),
      .i_TX_DV       (tx_dv),
      .i_TX_Byte     (tx_byte),
      .o_TX_Ready    (tx_ready),
`ifdef SPI_UNDERRUN_EN
      .o_TX_Underrun (under),
`endif
      .o_Busy        (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // reference: one-deep holding register and per-word load rule
   bit         m_full = 0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] cur_exp;
   logic [7:0] rx_exp[$];
   logic [7:0] rx_got[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] m_load();
      if (m_full) begin
         m_full = 0;
         return m_hold;
      end
`ifdef SPI_UNDERRUN_EN
      m_under = 1;
`endif
      return 8'h00;
   endfunction

   always @(negedge clk)
      if (!rst && rx_dv) rx_got.push_back(rx_byte);

   task automatic offer(input logic [7:0] b);
      tx_dv   = 1'b1;
      tx_byte = b;
      if (!m_full) begin
         m_full = 1;
         m_hold = b;
`ifdef SPI_UNDERRUN_EN
         m_under = 0;
`endif
      end
      tick(1);
      tx_dv = 1'b0;
      check("tx_ready", tx_ready, !m_full);
   endtask

   task automatic cs_low();
      csn = 1'b0;
      cur_exp = m_load();
      tick(8);
      check("busy_hi", busy, 1);
      check("ready_start", tx_ready, !m_full);
   endtask

   task automatic word(input logic [7:0] m, input bit do_off,
                       input logic [7:0] ob);
      logic [7:0] mi;
      for (int i = 7; i >= 0; i--) begin
         mosi = m[i];
         if (do_off && i == 4) begin
            offer(ob);
            tick(3);
         end else begin
            tick(4);
         end
         sclk  = 1'b1;
         mi[i] = miso;
         tick(4);
         sclk = 1'b0;
      end
      check("miso_word", mi, cur_exp);
      rx_exp.push_back(m);
      cur_exp = m_load();
   endtask

   task automatic partial(input int nb);
      for (int i = 0; i < nb; i++) begin
         mosi = 1'($urandom);
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_high();
      csn = 1'b1;
      tick(8);
      check("busy_lo", busy, 0);
      check("miso_idle", miso, 0);
      check("rx_cnt", rx_got.size(), rx_exp.size());
      for (int k = 0; k < rx_exp.size() && k < rx_got.size(); k++)
         check("rx_byte", rx_got[k], rx_exp[k]);
      if (rx_exp.size() > 0)
         check("rx_last", rx_byte, rx_exp[rx_exp.size()-1]);
      rx_exp.delete();
      rx_got.delete();
   endtask

   initial begin
      rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
      tx_dv = 1'b0; tx_byte = 8'h00;
      tick(4);
      rst = 1'b0;
      tick(1);
      check("rst_miso", miso, 0);
      check("rst_dv", rx_dv, 0);
      check("rst_byte", rx_byte, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", tx_ready, 1);
`ifdef SPI_UNDERRUN_EN
      check("rst_under", under, 0);
`endif
      tick(8);

      // single word
      offer(8'hA5);
      cs_low();
      word(8'h3C, 0, 8'h00);
      cs_high();

      // back-to-back words with an offer during word 1
      offer(8'h11);
      cs_low();
      word(8'hF0, 1, 8'h22);
      word(8'h0F, 0, 8'h00);
      cs_high();

      // back-pressure: second offer ignored
      offer(8'h55);
      offer(8'h66);
      cs_low();
      word(8'h9A, 0, 8'h00);
      cs_high();

      // underrun / fill
      cs_low();
      word(8'h12, 0, 8'h00);
      word(8'h34, 0, 8'h00);
      cs_high();
`ifdef SPI_UNDERRUN_EN
      check("under_set", under, m_under);
      offer(8'h77);
      check("under_clr", under, m_under);
`endif

      // abort mid-word then a clean frame
      cs_low();
      partial(3);
      cs_high();
      cs_low();
      word(8'h81, 0, 8'h00);
      cs_high();

      // reset mid-frame with CS_n held low
      cs_low();
      partial(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      m_full = 0;
`ifdef SPI_UNDERRUN_EN
      m_under = 0;
`endif
      check("mr_miso", miso, 0);
      check("mr_byte", rx_byte, 0);
      check("mr_busy", busy, 0);
      check("mr_ready", tx_ready, 1);
      tick(6);
      partial(9);
      check("mr_nobusy", busy, 0);
      check("mr_norx", rx_got.size(), 0);
      cs_high();
      cs_low();
      word(8'hC3, 0, 8'h00);
      cs_high();

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(1, 0) == 1) offer(8'($urandom));
         cs_low();
         if ($urandom_range(5, 0) == 0) begin
            partial($urandom_range(7, 1));
         end else begin
            for (int w = $urandom_range(3, 1); w > 0; w--)
               word(8'($urandom), 1'($urandom), 8'($urandom));
         end
         cs_high();
`ifdef SPI_UNDERRUN_EN
         check("rnd_under", under, m_under);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
